reload_counter_sched: RTL and testbench

Round-robin scheduler that shares one self-reloading up-counter among NUM_REQ requesters. A granted requester supplies a load value and a reload count. The block loads the counter, lets it count up to all-ones, and reloads from the load value on each rollover until the requested number of reloads is used up. It then signals completion and re-arbitrates. It sits between timer clients and the shared counter datapath, and owns the counter register itself.

---
 rtl/reload_counter_sched.sv | 141 ++++++++++++++
 tb/tb_reload_counter_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reload_counter_sched.sv
// Round-robin scheduler sharing one self-reloading up-counter among NUM_REQ timer clients.
// The granted client's load value and reload count are latched at grant time.
//
// state | meaning
// IDLE  | no run active; arbitrate pending requests round-robin
// RUN   | counter owned by cur_id; count up to all-ones, reload or finish
// DONE  | one-cycle completion pulse for cur_id, then back to IDLE
module reload_counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4,
  parameter int REP_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*CNT_W-1:0]   load_val_i,
  input  logic [NUM_REQ*REP_W-1:0]   reps_i,
  input  logic                       abort_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       done_o,
  output logic [$clog2(NUM_REQ)-1:0] done_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [CNT_W-1:0]   load_q,    load_d;
  logic [REP_W-1:0]   reps_q,    reps_d;
  logic [ID_W-1:0]    cur_id_q,  cur_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic               done_q,    done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  int unsigned        idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_id_q) + i) % NUM_REQ;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    count_d   = count_q;
    load_d    = load_q;
    reps_d    = reps_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_RUN;
          gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          cur_id_d  = win_id;
          last_id_d = win_id;
          count_d   = load_val_i[int'(win_id)*CNT_W +: CNT_W];
          load_d    = load_val_i[int'(win_id)*CNT_W +: CNT_W];
          reps_d    = reps_i[int'(win_id)*REP_W +: REP_W];
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + 1'b1;
        end else if (reps_q != '0) begin
          count_d = load_q;
          reps_d  = reps_q - 1'b1;
        end else begin
          state_d   = S_DONE;
          gnt_d     = '0;
          count_d   = '0;
          done_d    = 1'b1;
          done_id_d = cur_id_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      count_q   <= '0;
      load_q    <= '0;
      reps_q    <= '0;
      cur_id_q  <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      count_q   <= count_d;
      load_q    <= load_d;
      reps_q    <= reps_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q == S_RUN);
  assign count_o   = count_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;

endmodule

// File: tb/tb_reload_counter_sched.sv
// Directed bench for reload_counter_sched with hand-computed expectations.
module tb_reload_counter_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] load_val;
  logic [11:0] reps;
  logic        abort;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  count;
  logic        done;
  logic [1:0]  done_id;

  int n_checks = 0;
  int n_errors = 0;

  reload_counter_sched #(.NUM_REQ(4), .CNT_W(4), .REP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .load_val_i (load_val),
    .reps_i     (reps),
    .abort_i    (abort),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .count_o    (count),
    .done_o     (done),
    .done_id_o  (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    load_val = '0;
    reps     = '0;
    abort    = 1'b0;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    rst_n = 1'b1;
    step();

    // single request: load 12, no reloads
    req = 4'b0001; load_val[0 +: 4] = 4'd12; reps[0 +: 3] = 3'd0;
    step();
    load_val[0 +: 4] = 4'd3;  // changes after the grant edge must be ignored
    for (int i = 0; i < 4; i++) begin
      chk("t1_gnt", 32'(gnt), 1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_count", 32'(count), 32'(12 + i));
      chk("t1_done_low", 32'(done), 0);
      step();
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_done_id", 32'(done_id), 0);
    chk("t1_done_gnt", 32'(gnt), 0);
    chk("t1_done_count", 32'(count), 0);
    req = 4'b0000;
    step();
    chk("t1_idle_done", 32'(done), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_count", 32'(count), 0);

    // reload: requester 2, load 14, two reloads
    req = 4'b0100; load_val[8 +: 4] = 4'd14; reps[6 +: 3] = 3'd2;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t2_gnt", 32'(gnt), 4);
      chk("t2_count", 32'(count), (i % 2 == 0) ? 14 : 15);
      step();
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_done_id", 32'(done_id), 2);
    req = 4'b0000;
    step();

    // round robin: all requesting, one-cycle runs; last winner was 2
    load_val = 16'hFFFF; reps = '0; req = 4'b1111;
    step();
    begin
      int exp_order[5] = '{3, 0, 1, 2, 3};
      for (int k = 0; k < 5; k++) begin
        chk("t3_gnt", 32'(gnt), 32'(1 << exp_order[k]));
        chk("t3_count", 32'(count), 15);
        step();
        chk("t3_done", 32'(done), 1);
        chk("t3_done_id", 32'(done_id), 32'(exp_order[k]));
        if (k == 4) req = 4'b0000;
        step();
        chk("t3_idle_done", 32'(done), 0);
        chk("t3_idle_busy", 32'(busy), 0);
        if (k < 4) step();
      end
    end

    // boundary: load 0, seven reloads -> 128 cycles; last winner was 3
    load_val[0 +: 4] = 4'd0; reps[0 +: 3] = 3'd7; req = 4'b0001;
    step();
    for (int i = 0; i < 128; i++) begin
      chk("t4_count", 32'(count), 32'(i % 16));
      if (i % 16 == 0) chk("t4_busy", 32'(busy), 1);
      step();
    end
    chk("t4_done", 32'(done), 1);
    chk("t4_done_id", 32'(done_id), 0);
    req = 4'b0000;
    step();

    // abort: requester 1 running, abort at count 9, then 0 and 1 pending
    load_val[4 +: 4] = 4'd5; reps[3 +: 3] = 3'd0;
    load_val[0 +: 4] = 4'd15; reps[0 +: 3] = 3'd0;
    req = 4'b0010;
    step();
    chk("t5_gnt", 32'(gnt), 2);
    step(); step(); step(); step();
    chk("t5_count9", 32'(count), 9);
    abort = 1'b1; req = 4'b0011;
    step();
    abort = 1'b0;
    chk("t5_abort_gnt", 32'(gnt), 0);
    chk("t5_abort_count", 32'(count), 0);
    chk("t5_abort_done", 32'(done), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    step();
    chk("t5_regrant", 32'(gnt), 1);
    chk("t5_regrant_count", 32'(count), 15);
    step();
    chk("t5_done", 32'(done), 1);
    chk("t5_done_id", 32'(done_id), 0);
    req = 4'b0000;
    step();

    // reset mid-run: requester 0 long run, then reset, then requester 3
    reps[0 +: 3] = 3'd7; req = 4'b0001;
    step();
    step(); step();
    chk("t6_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_done", 32'(done), 0);
    req = 4'b1000; load_val[12 +: 4] = 4'd10; reps[9 +: 3] = 3'd0;
    #2 rst_n = 1'b1;
    step();
    chk("t6_gnt3", 32'(gnt), 8);
    for (int i = 0; i < 6; i++) begin
      chk("t6_count", 32'(count), 32'(10 + i));
      chk("t6_no_done", 32'(done), 0);
      step();
    end
    chk("t6_done", 32'(done), 1);
    chk("t6_done_id", 32'(done_id), 3);
    req = 4'b0000;
    step();
    chk("t6_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
